// File: rtl/store_monitor_pkg.sv
// ----------------------------------------------------------------------------
// store_monitor_pkg
// Shared types and constants for the store monitor.
//   mon_state_t   : monitor FSM states (RUN, PASS, TIMEOUT)
//   store_entry_t : one buffered store {adr, data[, ts]}
//   CNT_W         : width of the cycle counter, store counter and timestamps
// Optional feature macro: STORE_MONITOR_TIMESTAMP_EN adds the ts field.
// ----------------------------------------------------------------------------
package store_monitor_pkg;

    localparam int CNT_W = 16;
    // Field width for addresses/data held in an entry; the monitor's N must
    // not exceed this.
    localparam int MON_W = 32;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        PASS    = 2'd1,
        TIMEOUT = 2'd2
    } mon_state_t;

    typedef struct packed {
        logic [MON_W-1:0] adr;
        logic [MON_W-1:0] data;
`ifdef STORE_MONITOR_TIMESTAMP_EN
        logic [CNT_W-1:0] ts;
`endif
    } store_entry_t;

endpackage

// File: rtl/store_monitor_if.sv
// ----------------------------------------------------------------------------
// store_monitor_if
// Bundles the memory write-port snoop, the FIFO readout and the result flags.
//   master : computer/consumer side (drives memwrite, dataadr, writedata, pop)
//   slave  : monitor side (drives head_*, full, overflow, store_count, pass,
//            timeout and, with STORE_MONITOR_TIMESTAMP_EN, head_ts)
// ----------------------------------------------------------------------------
interface store_monitor_if #(
    parameter int N = 32
);
    logic         memwrite;
    logic [N-1:0] dataadr;
    logic [N-1:0] writedata;
    logic         pop;
    logic [N-1:0] head_adr;
    logic [N-1:0] head_data;
    logic         head_valid;
    logic         full;
    logic         overflow;
    logic [15:0]  store_count;
    logic         pass;
    logic         timeout;
`ifdef STORE_MONITOR_TIMESTAMP_EN
    logic [15:0]  head_ts;
`endif

    modport master (
        output memwrite, dataadr, writedata, pop,
        input  head_adr, head_data, head_valid, full, overflow,
               store_count, pass, timeout
`ifdef STORE_MONITOR_TIMESTAMP_EN
        , input head_ts
`endif
    );

    modport slave (
        input  memwrite, dataadr, writedata, pop,
        output head_adr, head_data, head_valid, full, overflow,
               store_count, pass, timeout
`ifdef STORE_MONITOR_TIMESTAMP_EN
        , output head_ts
`endif
    );
endinterface

// File: rtl/store_monitor_sync_fifo.sv
// ----------------------------------------------------------------------------
// sync_fifo
// First-word-fall-through FIFO, one clock, synchronous active-high reset.
//   clk, srst : clock and reset
//   push/din  : write request and entry
//   pop       : read request (ignored while empty)
//   head      : entry at the read pointer (raw; caller gates with empty)
//   count     : occupancy 0..DEPTH
//   full/empty: occupancy flags
// A push while full is accepted only when a pop frees a slot that cycle.
// DEPTH must be a power of two so the pointers wrap naturally.
// ----------------------------------------------------------------------------
module sync_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 8
) (
    input  logic                         clk,
    input  logic                         srst,
    input  logic                         push,
    input  logic                         pop,
    input  logic [W-1:0]                 din,
    output logic [W-1:0]                 head,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          w_push;
    logic          w_pop;

    assign empty  = (r_count == '0);
    assign full   = (r_count == CW'(DEPTH));
    assign count  = r_count;
    assign w_pop  = pop && !empty;
    assign w_push = push && (!full || w_pop);
    assign head   = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_push && !srst) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end
endmodule

// File: rtl/store_monitor.sv
// ----------------------------------------------------------------------------
// store_monitor
// Observes the data-memory write port, buffers every store made while running
// and reports pass (signature store seen) or timeout (budget expired).
//   clk   : system clock, all logic on posedge
//   reset : synchronous, active-high; clears everything, same-cycle store lost
//   bus   : store_monitor_if.slave (snoop inputs, pop, FIFO head, flags)
// Optional feature macro: STORE_MONITOR_TIMESTAMP_EN records the cycle count
// with each entry and drives bus.head_ts.
// TIMEOUT must fit the 16-bit cycle counter.
// ----------------------------------------------------------------------------
module store_monitor
    import store_monitor_pkg::*;
#(
    parameter int           N         = 32,
    parameter int           DEPTH     = 8,
    parameter logic [N-1:0] PASS_ADDR = N'(84),
    parameter logic [N-1:0] PASS_DATA = N'(32'h00000096),
    parameter int           TIMEOUT   = 1000
) (
    input  logic           clk,
    input  logic           reset,
    store_monitor_if.slave bus
);
    localparam int                CW       = $clog2(DEPTH+1);
    localparam logic [CNT_W-1:0]  LAST_CYC = CNT_W'(TIMEOUT - 1);

    mon_state_t       r_state;
    logic [CNT_W-1:0] r_cyc;
    logic [CNT_W-1:0] r_store_count;
    logic             r_overflow;
    logic             r_pass;
    logic             r_timeout;

    logic             w_run;
    logic             w_store;
    logic             w_match;
    logic             w_expire;
    logic             w_full;
    logic             w_empty;
    logic [CW-1:0]    w_count;
    store_entry_t     w_entry;
    store_entry_t     w_head;

    assign w_run    = (r_state == RUN);
    assign w_store  = w_run && bus.memwrite;
    assign w_match  = w_store && (bus.dataadr == PASS_ADDR) && (bus.writedata == PASS_DATA);
    assign w_expire = (r_cyc == LAST_CYC);

    always_comb begin
        w_entry      = '0;
        w_entry.adr  = MON_W'(bus.dataadr);
        w_entry.data = MON_W'(bus.writedata);
`ifdef STORE_MONITOR_TIMESTAMP_EN
        w_entry.ts   = r_cyc;
`endif
    end

    sync_fifo #(
        .W     ($bits(store_entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .srst  (reset),
        .push  (w_store),
        .pop   (bus.pop),
        .din   (w_entry),
        .head  (w_head),
        .count (w_count),
        .full  (w_full),
        .empty (w_empty)
    );

    // Head fields read as zero while empty so stale RAM never leaks out.
    assign bus.head_valid  = (w_count != '0);
    assign bus.head_adr    = w_empty ? '0 : N'(w_head.adr);
    assign bus.head_data   = w_empty ? '0 : N'(w_head.data);
`ifdef STORE_MONITOR_TIMESTAMP_EN
    assign bus.head_ts     = w_empty ? '0 : w_head.ts;
`endif
    assign bus.full        = w_full;
    assign bus.overflow    = r_overflow;
    assign bus.store_count = r_store_count;
    assign bus.pass        = r_pass;
    assign bus.timeout     = r_timeout;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= RUN;
            r_cyc         <= '0;
            r_store_count <= '0;
            r_overflow    <= 1'b0;
            r_pass        <= 1'b0;
            r_timeout     <= 1'b0;
        end else begin
            if (w_store) begin
                if (r_store_count != '1) r_store_count <= r_store_count + 1'b1;
                // A pop in the same cycle frees the slot, so only a push
                // into a full FIFO without a pop loses data.
                if (w_full && !bus.pop) r_overflow <= 1'b1;
            end
            case (r_state)
                RUN: begin
                    r_cyc <= r_cyc + 1'b1;
                    // Match is checked first so it wins over expiry.
                    if (w_match) begin
                        r_state <= PASS;
                        r_pass  <= 1'b1;
                    end else if (w_expire) begin
                        r_state   <= store_monitor_pkg::TIMEOUT;
                        r_timeout <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_store_monitor.sv
module tb_store_monitor;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rst_to = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    store_monitor_if #(.N(32)) bus ();
    store_monitor_if #(.N(32)) bus_to ();

    store_monitor dut (
        .clk   (clk),
        .reset (rst),
        .bus   (bus.slave)
    );

    store_monitor #(.TIMEOUT(20)) dut_to (
        .clk   (clk),
        .reset (rst_to),
        .bus   (bus_to.slave)
    );

    typedef struct {
        logic        rst;
        logic        mw;
        logic [31:0] adr;
        logic [31:0] data;
        logic        pop;
        logic        hv;
        logic [31:0] hadr;
        logic [31:0] hdata;
        logic        full;
        logic        ovf;
        logic [15:0] cnt;
        logic        pass;
    } vec_t;

    vec_t vecs[64];
    int   nv = 0;

    task automatic add(input logic r, input logic mw, input logic [31:0] a, input logic [31:0] d,
                       input logic p, input logic hv, input logic [31:0] ha, input logic [31:0] hd,
                       input logic f, input logic o, input logic [15:0] c, input logic ps);
        vecs[nv] = '{r, mw, a, d, p, hv, ha, hd, f, o, c, ps};
        nv++;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.memwrite = 0; bus.dataadr = 0; bus.writedata = 0; bus.pop = 0;
        bus_to.memwrite = 0; bus_to.dataadr = 0; bus_to.writedata = 0; bus_to.pop = 0;

        // Basic capture, pass and drain
        add(1,0,0,0,0,     0,0,0,0,0,0,0);
        add(0,1,16,5,0,    1,16,5,0,0,1,0);
        add(0,1,20,7,0,    1,16,5,0,0,2,0);
        add(0,1,84,'h96,0, 1,16,5,0,0,3,1);
        add(0,0,0,0,1,     1,20,7,0,0,3,1);
        add(0,0,0,0,1,     1,84,'h96,0,0,3,1);
        add(0,0,0,0,1,     0,0,0,0,0,3,1);
        add(0,1,30,3,1,    0,0,0,0,0,3,1);
        // Fill, push+pop at full, then overflow
        add(1,1,50,1,0,    0,0,0,0,0,0,0);
        for (int i = 0; i < 8; i++)
            add(0,1,100+i,i,0, 1,100,0,(i==7),0,16'(i+1),0);
        add(0,1,200,'hAA,1, 1,101,1,1,0,9,0);
        add(0,1,300,1,0,    1,101,1,1,1,10,0);
        add(0,1,301,2,0,    1,101,1,1,1,11,0);
        add(0,0,0,0,1,      1,102,2,0,1,11,0);
        // Reset while holding entries and pass
        add(1,0,0,0,0,     0,0,0,0,0,0,0);
        for (int i = 0; i < 4; i++)
            add(0,1,40+i,i,0, 1,40,0,0,0,16'(i+1),0);
        add(0,1,84,'h96,0, 1,40,0,0,0,5,1);
        add(1,1,84,'h96,0, 0,0,0,0,0,0,0);
        add(0,0,0,0,0,     0,0,0,0,0,0,0);

        for (int r = 0; r < nv; r++) begin
            rst          = vecs[r].rst;
            bus.memwrite = vecs[r].mw;
            bus.dataadr  = vecs[r].adr;
            bus.writedata= vecs[r].data;
            bus.pop      = vecs[r].pop;
            tick();
            $display("row %0d: rst=%0d mw=%0d adr=%0d data=%0h pop=%0d -> hv=%0d head=(%0d,%0h) cnt=%0d pass=%0d",
                     r, vecs[r].rst, vecs[r].mw, vecs[r].adr, vecs[r].data, vecs[r].pop,
                     bus.head_valid, bus.head_adr, bus.head_data, bus.store_count, bus.pass);
            check($sformatf("row%0d head_valid", r), 32'(bus.head_valid), 32'(vecs[r].hv));
            check($sformatf("row%0d head_adr", r),   bus.head_adr,         vecs[r].hadr);
            check($sformatf("row%0d head_data", r),  bus.head_data,        vecs[r].hdata);
            check($sformatf("row%0d full", r),       32'(bus.full),        32'(vecs[r].full));
            check($sformatf("row%0d overflow", r),   32'(bus.overflow),    32'(vecs[r].ovf));
            check($sformatf("row%0d store_count", r),32'(bus.store_count), 32'(vecs[r].cnt));
            check($sformatf("row%0d pass", r),       32'(bus.pass),        32'(vecs[r].pass));
            check($sformatf("row%0d timeout", r),    32'(bus.timeout),     32'h0);
        end
        rst = 0;
        bus.memwrite = 0; bus.pop = 0;

        // Timeout after exactly 20 RUN cycles, later signature ignored
        rst_to = 1; tick(); rst_to = 0;
        check("to reset timeout", 32'(bus_to.timeout), 0);
        repeat (19) tick();
        check("to before expiry", 32'(bus_to.timeout), 0);
        tick();
        $display("timeout seq: after 20 cycles timeout=%0d pass=%0d", bus_to.timeout, bus_to.pass);
        check("to at expiry", 32'(bus_to.timeout), 1);
        check("to pass low", 32'(bus_to.pass), 0);
        bus_to.memwrite = 1; bus_to.dataadr = 84; bus_to.writedata = 'h96;
        tick();
        bus_to.memwrite = 0;
        check("to late sig pass", 32'(bus_to.pass), 0);
        check("to late sig count", 32'(bus_to.store_count), 0);
        check("to late sig hv", 32'(bus_to.head_valid), 0);

        // Match on the expiry cycle: pass wins
        rst_to = 1; tick(); rst_to = 0;
        repeat (19) tick();
        bus_to.memwrite = 1; bus_to.dataadr = 84; bus_to.writedata = 'h96;
        tick();
        bus_to.memwrite = 0;
        $display("tie seq: pass=%0d timeout=%0d", bus_to.pass, bus_to.timeout);
        check("tie pass", 32'(bus_to.pass), 1);
        check("tie timeout", 32'(bus_to.timeout), 0);
        check("tie count", 32'(bus_to.store_count), 1);
        repeat (5) tick();
        check("tie terminal timeout", 32'(bus_to.timeout), 0);

`ifdef STORE_MONITOR_TIMESTAMP_EN
        // Stores at RUN cycles 3 and 7
        rst = 1; tick(); rst = 0;
        check("ts empty", 32'(bus.head_ts), 0);
        repeat (3) tick();
        bus.memwrite = 1; bus.dataadr = 8; bus.writedata = 1; tick();
        bus.memwrite = 0;
        repeat (3) tick();
        bus.memwrite = 1; bus.dataadr = 12; bus.writedata = 2; tick();
        bus.memwrite = 0;
        $display("ts seq: head_ts=%0d", bus.head_ts);
        check("ts first", 32'(bus.head_ts), 3);
        bus.pop = 1; tick(); bus.pop = 0;
        check("ts second", 32'(bus.head_ts), 7);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/store_monitor.md
Name: store_monitor

Overview:
- Synthesizable observer that sits directly downstream of the computer's data-memory write port and consumes its memwrite/dataadr/writedata bus.
- Buffers every store in a small FIFO for later readout.
- Flags pass when the signature store (address 84, data 0x96) is seen.
- Flags timeout if no pass occurs within a cycle budget.
- Replaces ad-hoc bench checks with a reusable in-design result checker.

Parameters:
- N, 32, data and address width.
- DEPTH, 8, FIFO entries; power of two, ≥2.
- PASS_ADDR, 84, signature store address.
- PASS_DATA, 32'h00000096, signature store data.
- TIMEOUT, 1000, cycles allowed in RUN before timeout; ≥1.

Ports:
- clk  input  1  system clock; all logic on posedge.
- reset  input  1  synchronous, active-high.
- memwrite  input  1  store strobe from computer.
- dataadr  input  N  store address.
- writedata  input  N  store data.
- pop  input  1  consumer pops FIFO head this cycle.
- head_adr  output  N  address of FIFO head.
- head_data  output  N  data of FIFO head.
- head_valid  output  1  FIFO non-empty.
- full  output  1  FIFO holds DEPTH entries.
- overflow  output  1  sticky: a store was dropped.
- store_count  output  16  total stores observed in RUN; saturates at 16'hFFFF.
- pass  output  1  signature store seen.
- timeout  output  1  budget expired without pass.

Behaviour:
- Interface decision: one clock, clk. Reset is reset, synchronous and active-high.
- Reset values: state=RUN, FIFO empty, cycle counter 0. All outputs 0, including head_adr and head_data.
- Reset asserted mid-operation: all state clears on that edge. Stores presented in the same cycle as reset are ignored.
- FSM has three states: RUN, PASS, TIMEOUT.
  - RUN → PASS when memwrite=1 and dataadr==PASS_ADDR and writedata==PASS_DATA.
  - RUN → TIMEOUT when the cycle counter equals TIMEOUT-1 and no match occurs this cycle.
  - Match and expiry in the same cycle: PASS wins.
  - PASS and TIMEOUT are terminal until reset.
- pass=(state==PASS) and timeout=(state==TIMEOUT), both registered. Each rises one cycle after the triggering edge sample.
- Cycle counter: increments every cycle in RUN; frozen in terminal states.
- Capture:
  - In RUN, memwrite=1 pushes {dataadr, writedata}. This includes the matching store.
  - In PASS and TIMEOUT no pushes occur and store_count freezes. pop still drains the FIFO.
- store_count increments on each RUN store, whether pushed or dropped.
- FIFO:
  - First-word-fall-through. head_* is valid whenever head_valid=1.
  - Latency: a store sampled at edge k appears at head at k+1 if the FIFO was empty.
  - pop while empty: ignored, no pointer change.
  - Push while full with no pop: store dropped, overflow set sticky.
  - Push and pop while full: both occur, occupancy stays DEPTH, no overflow.
  - Push and pop while empty: push only.
  - Pointers are log2(DEPTH) bits and wrap modulo DEPTH. Full/empty is tracked with an occupancy count 0..DEPTH.
- head_adr and head_data read 0 when empty.

Optional Feature:
- Macro: STORE_MONITOR_TIMESTAMP_EN.
- When defined:
  - Each entry also records the 16-bit cycle counter value at push.
  - Adds output head_ts[15:0], 0 when empty.
- When undefined:
  - No head_ts port and no timestamp storage.
  - All other behaviour is identical.

Decomposition:
- Package store_monitor_pkg holds:
  - state enum mon_state_t {RUN, PASS, TIMEOUT}.
  - packed struct store_entry_t {adr, data[, ts]}.
  - localparam CNT_W=16.
- One sub-module: sync_fifo, parameterized on entry type width and DEPTH. It provides push, pop, head, count, full and empty.
- The FSM, counters and match logic stay in store_monitor.

Test Plan:
- Reset then stores (16,5), (20,7), (84,0x96) on consecutive cycles → pass=1 the cycle after the third store, store_count=3, pops return (16,5), (20,7), (84,0x96), then head_valid=0.
- TIMEOUT=20, no memwrite → timeout=1 after exactly 20 RUN cycles, pass stays 0; a later (84,0x96) store does not set pass and store_count stays 0.
- DEPTH=8, 10 non-matching stores with no pop → full=1 after 8, overflow=1, store_count=10, head=first store.
- FIFO full, then push and pop in the same cycle → occupancy stays 8, overflow unchanged, head advances to second entry.
- Reset asserted with 5 entries buffered and pass=1 → next cycle head_valid=0, pass=0, store_count=0, overflow=0.
- With STORE_MONITOR_TIMESTAMP_EN: stores at RUN cycles 3 and 7 → head_ts reads 3, then 7 after one pop.
